gt_line_memory: RTL and testbench



---
 rtl/gt_line_memory.sv | 173 +++++++++++++++++
 tb/tb_gt_line_memory.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_line_memory.sv
// gt_line_memory: fixed-latency backing-memory responder for the GT
// direct-mapped cache. It accepts one line fill or writeback at a time and
// returns a one-cycle response pulse LATENCY edges after acceptance. Storage
// is a small tagged line array. Lines that were never written (or whose tag
// does not match) return a deterministic fill pattern.
module gt_line_memory #(
  parameter int unsigned LINES_LOG2 = 4,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned TAG_W      = 32 - 5 - LINES_LOG2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [255:0] toMemData,
  output logic [255:0] memData,
  output logic         rsp_valid,
  output logic         rsp_is_write
);

  localparam int unsigned LINES    = 1 << LINES_LOG2;
  // The counter is loaded with LATENCY-1 so that it reaches zero exactly
  // LATENCY-1 edges after acceptance; the next edge enters RESP.
  localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Halfword k of the fill pattern holds its own index replicated four
  // times: FFFF_EEEE_..._1111_0000.
  function automatic logic [255:0] fill_pattern();
    logic [255:0] fp;
    fp = 256'd0;
    for (int k = 0; k < 16; k++) begin
      fp[16*k +: 16] = {4{k[3:0]}};
    end
    return fp;
  endfunction

  localparam logic [255:0] FILL_PAT = fill_pattern();

  // Control and latched-request state
  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [LINES_LOG2-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [255:0]            data_q, data_d;

  // Registered outputs
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_is_write_q, rsp_is_write_d;
  logic [255:0]            mem_data_q, mem_data_d;

  // Line array: only the valid bits are reset
  logic [LINES-1:0]        line_valid_q, line_valid_d;
  logic [255:0]            line_data_q [LINES];
  logic [TAG_W-1:0]        line_tag_q [LINES];

  logic                    accept_s;
  logic                    hit_s;
  logic                    commit_wr_s;

  // Byte-offset bits of the address carry no information for a line memory
  logic                    unused_addr_s;
  assign unused_addr_s = ^req_addr[4:0];

  // Next-state, request latching, line operation and output computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    idx_d          = idx_q;
    tag_d          = tag_q;
    data_d         = data_q;
    rsp_is_write_d = rsp_is_write_q;
    mem_data_d     = mem_data_q;
    line_valid_d   = line_valid_q;
    commit_wr_s    = 1'b0;

    accept_s = req_ready_q & req_valid;
    hit_s    = line_valid_q[idx_q] & (line_tag_q[idx_q] == tag_q);

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          wr_d    = req_write;
          idx_d   = req_addr[5 +: LINES_LOG2];
          tag_d   = req_addr[31 -: TAG_W];
          data_d  = toMemData;
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RESP;
          if (wr_q) begin
            commit_wr_s         = 1'b1;
            line_valid_d[idx_q] = 1'b1;
            rsp_is_write_d      = 1'b1;
          end else begin
            rsp_is_write_d = 1'b0;
            mem_data_d     = hit_s ? line_data_q[idx_q] : FILL_PAT;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready and response pulse are registered views of the next state
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      wr_q           <= 1'b0;
      idx_q          <= '0;
      tag_q          <= '0;
      data_q         <= 256'd0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      mem_data_q     <= 256'd0;
      line_valid_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_q           <= wr_d;
      idx_q          <= idx_d;
      tag_q          <= tag_d;
      data_q         <= data_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
      mem_data_q     <= mem_data_d;
      line_valid_q   <= line_valid_d;
    end
  end

  // Line data and tag storage; a reset edge suppresses a pending commit
  always_ff @(posedge CLK) begin
    if (commit_wr_s && !RST) begin
      line_data_q[idx_q] <= data_q;
      line_tag_q[idx_q]  <= tag_q;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_is_write = rsp_is_write_q;
  assign memData      = mem_data_q;

endmodule

// File: tb/tb_gt_line_memory.sv
// Self-checking bench for gt_line_memory: a directed vector table, hand-written
// reset/backpressure sequences, and random traffic checked against a simple
// array model of the line memory. A second instance runs with LATENCY = 1.
module tb_gt_line_memory;

  localparam int LAT = 4;
  localparam logic [255:0] FP =
    256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [255:0] PAT_A = {8{32'hCAFE_0A0A}};
  localparam logic [255:0] PAT_B = {8{32'hBEEF_0B0B}};
  localparam logic [255:0] PAT_C = {8{32'h1357_9BDF}};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;

  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [255:0] toMemData = 256'd0;
  logic         req_ready, rsp_valid, rsp_is_write;
  logic [255:0] memData;

  logic         b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [31:0]  b_req_addr = 32'd0;
  logic [255:0] b_toMemData = 256'd0;
  logic         b_req_ready, b_rsp_valid, b_rsp_is_write;
  logic [255:0] b_memData;

  gt_line_memory #(.LATENCY(LAT)) dut4 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .toMemData(toMemData),
    .memData(memData), .rsp_valid(rsp_valid), .rsp_is_write(rsp_is_write)
  );

  gt_line_memory #(.LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .toMemData(b_toMemData),
    .memData(b_memData), .rsp_valid(b_rsp_valid), .rsp_is_write(b_rsp_is_write)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 16 direct-mapped lines, tag = addr[31:9]
  logic [255:0] m_data [16];
  logic [22:0]  m_tag  [16];
  bit           m_valid[16];
  logic [255:0] last_md = 256'd0;

  typedef struct {
    logic         w;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_md;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) & 32'd15);
  endfunction

  function automatic logic [255:0] model_read(input logic [31:0] a);
    int ix;
    ix = line_of(a);
    if (m_valid[ix] && (m_tag[ix] == a[31:9])) return m_data[ix];
    return FP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_md = 256'd0;
  endtask

  // One complete transaction on the LATENCY=4 instance, checking timing and payload
  task automatic txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                     input logic [255:0] exp_md, input string nm);
    int n;
    int lat;
    bit busy_ok;
    int ix;
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_addr = a; toMemData = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      chk({nm, "_accept_timeout"}, 256'd0, 256'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    // Scramble the request lines so only the latched copy can be used
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom(); toMemData = '1;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge CLK);
      lat++;
      if (!rsp_valid && req_ready) busy_ok = 1'b0;
    end while (!rsp_valid && lat < 300);
    chk({nm, "_latency"}, lat, LAT + 1);
    chk({nm, "_ready_low_while_busy"}, busy_ok, 1'b1);
    chk({nm, "_ready_in_resp"}, req_ready, 1'b0);
    chk({nm, "_is_write"}, rsp_is_write, w);
    chk({nm, "_memData"}, memData, exp_md);
    @(negedge CLK);
    chk({nm, "_pulse_end_ready"}, {rsp_valid, req_ready}, 2'b01);
    if (w) begin
      ix = line_of(a);
      m_data[ix]  = d;
      m_tag[ix]   = a[31:9];
      m_valid[ix] = 1'b1;
    end
    last_md = exp_md;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, rsp, cyc, last_acc;
    bit saw;
    logic [255:0] exp_q[$];
    logic [31:0] a;
    logic [255:0] d;
    logic w;

    vt[0] = '{1'b0, 32'h0010_0001, 256'd0,      FP};
    vt[1] = '{1'b1, 32'h0030_0003, 256'h1234,   FP};
    vt[2] = '{1'b0, 32'h0030_0000, 256'd0,      256'h1234};
    vt[3] = '{1'b1, 32'h0030_0003, PAT_A,       256'h1234};
    vt[4] = '{1'b1, 32'h0230_00F3, PAT_B,       256'h1234};
    vt[5] = '{1'b0, 32'h0230_00F3, 256'd0,      PAT_B};
    vt[6] = '{1'b0, 32'h0030_0003, 256'd0,      PAT_A};
    vt[7] = '{1'b1, 32'h0230_0003, PAT_C,       PAT_A};
    vt[8] = '{1'b0, 32'h0230_0003, 256'd0,      PAT_C};
    vt[9] = '{1'b0, 32'h0030_0003, 256'd0,      FP};

    // Reset state
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ready", req_ready, 1'b0);
    chk("reset_rsp", {rsp_valid, rsp_is_write}, 2'b00);
    chk("reset_memData", memData, 256'd0);
    chk("reset_ready_l1", b_req_ready, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_release", {req_ready, b_req_ready}, 2'b11);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      txn(vt[i].w, vt[i].addr, vt[i].data, vt[i].exp_md, $sformatf("vec%0d", i));
    end

    // req_valid held high: alternating reads, one response per acceptance
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0230_00F3;
    acc = 0; rsp = 0; cyc = 0; last_acc = 0;
    while ((acc < 4 || rsp < acc) && cyc < 100) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("held_extra_rsp", 256'd1, 256'd0);
        end else begin
          last_md = exp_q.pop_front();
          chk("held_rsp_data", memData, last_md);
          chk("held_rsp_kind", rsp_is_write, 1'b0);
        end
        rsp++;
      end
      if (req_ready && req_valid) begin
        if (acc > 0) chk("held_accept_spacing", cyc - last_acc, LAT + 2);
        last_acc = cyc;
        exp_q.push_back(model_read(req_addr));
        acc++;
        @(posedge CLK);
        #1;
        req_addr = (acc % 2 == 1) ? 32'h0050_0000 : 32'h0230_00F3;
        if (acc == 4) req_valid = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    chk("held_accept_count", acc, 4);
    chk("held_rsp_count", rsp, 4);
    saw = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid) saw = 1'b1;
    end
    chk("held_no_stray_rsp", saw, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 30; i++) begin
      int tg_sel, ix;
      tg_sel = $urandom_range(0, 2);
      ix = (i % 5 == 4) ? 7 : $urandom_range(0, 3);
      a = ((tg_sel == 0 ? 32'h1800 : (tg_sel == 1 ? 32'h11800 : 32'h5)) << 9)
          | (32'(ix) << 5) | 32'($urandom_range(0, 31));
      for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom();
      w = 1'($urandom_range(0, 1));
      txn(w, a, d, w ? last_md : model_read(a), $sformatf("rnd%0d", i));
    end

    // Reset two cycles after accepting a write: abandoned, not committed
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0020_0002; toMemData = 256'hAB;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid_accept", n < 50, 1'b1);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid) saw = 1'b1;
    end
    chk("rst_mid_ready_low", req_ready, 1'b0);
    chk("rst_mid_memData_cleared", memData, 256'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    @(negedge CLK);
    if (rsp_valid) saw = 1'b1;
    @(negedge CLK);
    if (rsp_valid) saw = 1'b1;
    chk("rst_mid_ready_after_release", req_ready, 1'b1);
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid) saw = 1'b1;
    end
    chk("rst_mid_no_rsp", saw, 1'b0);
    txn(1'b0, 32'h0020_0002, 256'd0, FP, "rst_mid_readback");

    // LATENCY = 1 instance: read timing
    @(negedge CLK);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0010_0001;
    n = 0;
    while (!b_req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("l1_accept", n < 20, 1'b1);
    @(posedge CLK);
    #1 b_req_valid = 1'b0;
    @(negedge CLK);
    chk("l1_busy", {b_rsp_valid, b_req_ready}, 2'b00);
    @(negedge CLK);
    chk("l1_rsp", {b_rsp_valid, b_rsp_is_write, b_req_ready}, 3'b100);
    chk("l1_data", b_memData, FP);
    @(negedge CLK);
    chk("l1_idle", {b_rsp_valid, b_req_ready}, 2'b01);

    // Simultaneous RST and req_valid: reset wins, nothing accepted
    @(negedge CLK);
    RST = 1'b1; b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0030_0000;
    @(posedge CLK);
    #1;
    RST = 1'b0; b_req_valid = 1'b0;
    model_reset();
    saw = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (b_rsp_valid) saw = 1'b1;
    end
    chk("l1_rst_wins_no_rsp", saw, 1'b0);
    chk("l1_rst_wins_ready", b_req_ready, 1'b1);
    chk("l1_rst_wins_memData", b_memData, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
